// File: rtl/oh_to_idx_buffered_if.sv
// Handshake bundle for the buffered one-hot to index encoder.
// Producer side offers one-hot vectors, consumer side takes encoded entries.
interface oh_to_idx_buffered_if #(
   parameter int NUM_SIGNALS = 4,
   parameter int INDEX_WIDTH = $clog2(NUM_SIGNALS)
);
   logic                   in_valid;
   logic                   in_ready;
   logic [NUM_SIGNALS-1:0] in_one_hot;
   logic                   out_valid;
   logic                   out_ready;
   logic [INDEX_WIDTH-1:0] out_index;
   logic                   out_zero;
   logic                   out_multi;

   modport master (
      output in_valid,
      output in_one_hot,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_index,
      input  out_zero,
      input  out_multi
   );

   modport slave (
      input  in_valid,
      input  in_one_hot,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_index,
      output out_zero,
      output out_multi
   );
endinterface

// File: rtl/oh_to_idx_buffered.sv
// Registered one-hot to index encoder with a 2-entry output buffer,
// zero/multi-hot flags and a saturating error counter.
module oh_to_idx_buffered #(
   parameter int    NUM_SIGNALS     = 4,
   parameter string DIRECTION       = "LSB0",
   parameter int    INDEX_WIDTH     = $clog2(NUM_SIGNALS),
   parameter int    ERR_COUNT_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   oh_to_idx_buffered_if.slave        bus,
   input  logic                       err_count_clear,
   output logic [ERR_COUNT_WIDTH-1:0] err_count
);
   localparam bit MSB0 = (DIRECTION == "MSB0");
   localparam int EW   = INDEX_WIDTH + 2;

   generate
      if (INDEX_WIDTH < $clog2(NUM_SIGNALS)) begin : g_bad_index_width
         $error("INDEX_WIDTH too small for NUM_SIGNALS");
      end
      if (NUM_SIGNALS < 2) begin : g_bad_num_signals
         $error("NUM_SIGNALS must be at least 2");
      end
   endgenerate

   logic [INDEX_WIDTH-1:0] idx_c;
   logic                   zero_c;
   logic                   multi_c;
   logic [EW-1:0]          ent_c;
   logic [EW-1:0]          head;
   logic [EW-1:0]          tail;
   logic [1:0]             cnt;
   logic                   rdy;
   logic                   vld;
   logic                   push;
   logic                   pop;

   // Multi-hot inputs deliberately OR their indices together.
   always_comb begin
      idx_c = '0;
      for (int i = 0; i < NUM_SIGNALS; i++) begin
         if (bus.in_one_hot[i]) begin
            idx_c = idx_c | (MSB0 ? INDEX_WIDTH'(NUM_SIGNALS - 1 - i)
                                  : INDEX_WIDTH'(i));
         end
      end
   end

   assign zero_c  = (bus.in_one_hot == '0);
   assign multi_c = |(bus.in_one_hot & (bus.in_one_hot - NUM_SIGNALS'(1)));
   assign ent_c   = {idx_c, zero_c, multi_c};

   assign rdy  = reset & (cnt != 2'd2);
   assign vld  = (cnt != 2'd0);
   assign push = bus.in_valid & rdy;
   assign pop  = vld & bus.out_ready;

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld;
   assign {bus.out_index, bus.out_zero, bus.out_multi} = head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= 2'd0;
      end else begin
         if (pop && cnt == 2'd2) begin
            head <= tail;
         end else if (pop && push) begin
            head <= ent_c;
         end else if (push && cnt == 2'd0) begin
            head <= ent_c;
         end else if (push) begin
            tail <= ent_c;
         end
         unique case (1'b1)
            push && !pop: cnt <= cnt + 2'd1;
            pop && !push: cnt <= cnt - 2'd1;
            default: ;
         endcase
      end
   end

   // Clear wins over a same-cycle error push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_count <= '0;
      end else begin
         unique case (1'b1)
            err_count_clear: err_count <= '0;
            !err_count_clear && push && (zero_c || multi_c)
               && (err_count != '1):
               err_count <= err_count + ERR_COUNT_WIDTH'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_oh_to_idx_buffered.sv
// Bench for oh_to_idx_buffered: LSB0 and MSB0 instances driven in lockstep,
// directed table, reset-in-flight sequence and randomized model compare.
module tb_oh_to_idx_buffered;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] err_a;
   logic [7:0] err_b;

   oh_to_idx_buffered_if #(.NUM_SIGNALS(8), .INDEX_WIDTH(3)) bus_a ();
   oh_to_idx_buffered_if #(.NUM_SIGNALS(8), .INDEX_WIDTH(3)) bus_b ();

   oh_to_idx_buffered #(
      .NUM_SIGNALS(8), .DIRECTION("LSB0"),
      .INDEX_WIDTH(3), .ERR_COUNT_WIDTH(2)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a),
      .err_count_clear(clr), .err_count(err_a)
   );

   oh_to_idx_buffered #(
      .NUM_SIGNALS(8), .DIRECTION("MSB0"),
      .INDEX_WIDTH(3), .ERR_COUNT_WIDTH(8)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b),
      .err_count_clear(clr), .err_count(err_b)
   );

   always #5 clk = ~clk;

   logic       ir [2];
   logic       ov [2];
   logic [2:0] ix [2];
   logic       zf [2];
   logic       mf [2];
   logic [7:0] ec [2];

   assign ir[0] = bus_a.in_ready;
   assign ir[1] = bus_b.in_ready;
   assign ov[0] = bus_a.out_valid;
   assign ov[1] = bus_b.out_valid;
   assign ix[0] = bus_a.out_index;
   assign ix[1] = bus_b.out_index;
   assign zf[0] = bus_a.out_zero;
   assign zf[1] = bus_b.out_zero;
   assign mf[0] = bus_a.out_multi;
   assign mf[1] = bus_b.out_multi;
   assign ec[0] = {6'b0, err_a};
   assign ec[1] = err_b;

   int n_cmp;
   int n_bad;

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] @%0t: got %0h want %0h",
                  nm, k, $time, act, exp);
      end
   endtask

   task automatic drive(input int v, input int oh, input int r, input int c);
      bus_a.in_valid   = v[0];
      bus_b.in_valid   = v[0];
      bus_a.in_one_hot = oh[7:0];
      bus_b.in_one_hot = oh[7:0];
      bus_a.out_ready  = r[0];
      bus_b.out_ready  = r[0];
      clr              = c[0];
   endtask

   // Reference model: encoding from the bit-position rule, FIFO as array.
   typedef struct {
      int idx;
      int z;
      int m;
   } ent_t;

   ent_t mbuf [2][2];
   int   mcnt [2];
   int   merr [2];
   int   emax [2];

   function automatic int enc(input int oh, input int msb0);
      int r = 0;
      for (int i = 0; i < 8; i++)
         if (oh[i]) r = r | ((msb0 != 0) ? 7 - i : i);
      return r & 7;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0;
         merr[k] = 0;
      end
   endtask

   task automatic model_step(input int v, input int oh,
                             input int r, input int c);
      for (int k = 0; k < 2; k++) begin
         ent_t e;
         bit pu, po;
         pu = (v != 0) && (mcnt[k] < 2);
         po = (r != 0) && (mcnt[k] > 0);
         e.idx = enc(oh, k);
         e.z = (oh == 0) ? 1 : 0;
         e.m = ($countones(oh[7:0]) > 1) ? 1 : 0;
         if (po) begin
            mbuf[k][0] = mbuf[k][1];
            mcnt[k]--;
         end
         if (pu) begin
            mbuf[k][mcnt[k]] = e;
            mcnt[k]++;
         end
         if (c != 0) merr[k] = 0;
         else if (pu && (e.z + e.m) > 0 && merr[k] < emax[k]) merr[k]++;
      end
   endtask

   task automatic model_check();
      for (int k = 0; k < 2; k++) begin
         chk("rnd_in_ready", k, ir[k], (mcnt[k] < 2) ? 1 : 0);
         chk("rnd_out_valid", k, ov[k], (mcnt[k] > 0) ? 1 : 0);
         if (mcnt[k] > 0) begin
            chk("rnd_index", k, ix[k], mbuf[k][0].idx);
            chk("rnd_zero", k, zf[k], mbuf[k][0].z);
            chk("rnd_multi", k, mf[k], mbuf[k][0].m);
         end else begin
            chk("rnd_empty_noX", k,
                $isunknown({ix[k], zf[k], mf[k]}) ? 1 : 0, 0);
         end
         chk("rnd_err_count", k, ec[k], merr[k]);
      end
   endtask

   typedef struct {
      int v, oh, r, c;
      int rdy, ovld, ia, ib, z, m, err;
   } row_t;

   row_t tbl [20];

   function automatic row_t mk(int v, int oh, int r, int c, int rdy,
                               int ovld, int ia, int ib, int z, int m,
                               int err);
      row_t t;
      t.v = v; t.oh = oh; t.r = r; t.c = c;
      t.rdy = rdy; t.ovld = ovld; t.ia = ia; t.ib = ib;
      t.z = z; t.m = m; t.err = err;
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int v, oh, r, c, mode;
      n_cmp = 0;
      n_bad = 0;
      emax[0] = 3;
      emax[1] = 255;
      model_reset();

      //           v  oh    r  c  rdy ov ia ib z  m  err
      tbl[0]  = mk(1, 'h10, 1, 0, 1, 1, 4, 3, 0, 0, 0);
      tbl[1]  = mk(1, 'h80, 1, 0, 1, 1, 7, 0, 0, 0, 0);
      tbl[2]  = mk(1, 'h06, 1, 0, 1, 1, 3, 7, 0, 1, 1);
      tbl[3]  = mk(1, 'h00, 1, 0, 1, 1, 0, 0, 1, 0, 2);
      tbl[4]  = mk(0, 'h00, 1, 0, 1, 0, 0, 0, 0, 0, 2);
      tbl[5]  = mk(1, 'h02, 0, 0, 1, 1, 1, 6, 0, 0, 2);
      tbl[6]  = mk(1, 'h20, 0, 0, 0, 1, 1, 6, 0, 0, 2);
      tbl[7]  = mk(1, 'h80, 0, 0, 0, 1, 1, 6, 0, 0, 2);
      tbl[8]  = mk(1, 'h80, 1, 0, 1, 1, 5, 2, 0, 0, 2);
      tbl[9]  = mk(1, 'h80, 0, 0, 0, 1, 5, 2, 0, 0, 2);
      tbl[10] = mk(0, 'h00, 1, 0, 1, 1, 7, 0, 0, 0, 2);
      tbl[11] = mk(0, 'h00, 1, 0, 1, 0, 0, 0, 0, 0, 2);
      tbl[12] = mk(0, 'h00, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(1, 'h00, 1, 0, 1, 1, 0, 0, 1, 0, 1);
      tbl[14] = mk(1, 'h00, 1, 0, 1, 1, 0, 0, 1, 0, 2);
      tbl[15] = mk(1, 'h00, 1, 0, 1, 1, 0, 0, 1, 0, 3);
      tbl[16] = mk(1, 'h00, 1, 0, 1, 1, 0, 0, 1, 0, 3);
      tbl[17] = mk(1, 'h00, 1, 0, 1, 1, 0, 0, 1, 0, 3);
      tbl[18] = mk(1, 'h03, 1, 1, 1, 1, 1, 7, 0, 1, 0);
      tbl[19] = mk(0, 'h00, 1, 0, 1, 0, 0, 0, 0, 0, 0);

      drive(0, 0, 0, 0);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", k, ir[k], 0);
         chk("rst_out_valid", k, ov[k], 0);
         chk("rst_index", k, ix[k], 0);
         chk("rst_zero", k, zf[k], 0);
         chk("rst_multi", k, mf[k], 0);
         chk("rst_err_count", k, ec[k], 0);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_in_ready", 0, ir[0], 1);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].oh, tbl[i].r, tbl[i].c);
         @(posedge clk);
         #1;
         chk("tbl_in_ready", i, ir[0], tbl[i].rdy);
         chk("tbl_in_ready_b", i, ir[1], tbl[i].rdy);
         chk("tbl_out_valid", i, ov[0], tbl[i].ovld);
         chk("tbl_out_valid_b", i, ov[1], tbl[i].ovld);
         if (tbl[i].ovld != 0) begin
            chk("tbl_index_lsb0", i, ix[0], tbl[i].ia);
            chk("tbl_index_msb0", i, ix[1], tbl[i].ib);
            chk("tbl_zero", i, zf[0], tbl[i].z);
            chk("tbl_multi", i, mf[0], tbl[i].m);
         end
         chk("tbl_err_count", i, ec[0], tbl[i].err);
      end

      // Two entries in flight, then reset pulsed between clock edges.
      @(negedge clk);
      drive(1, 'h00, 0, 0);
      @(negedge clk);
      drive(1, 'h00, 0, 0);
      @(negedge clk);
      drive(0, 'h00, 0, 0);
      #1;
      chk("pre_rst_full", 0, ir[0], 0);
      chk("pre_rst_valid", 0, ov[0], 1);
      chk("pre_rst_err", 0, ec[0], 2);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("mid_rst_in_ready", k, ir[k], 0);
         chk("mid_rst_out_valid", k, ov[k], 0);
         chk("mid_rst_err_count", k, ec[k], 0);
         chk("mid_rst_index", k, ix[k], 0);
         chk("mid_rst_zero", k, zf[k], 0);
      end
      #1;
      reset = 1'b1;
      #1;
      chk("post_rst_in_ready", 0, ir[0], 1);
      chk("post_rst_out_valid", 0, ov[0], 0);
      @(negedge clk);
      drive(1, 'h40, 1, 0);
      @(posedge clk);
      #1;
      chk("post_rst_push_valid", 0, ov[0], 1);
      chk("post_rst_push_idx", 0, ix[0], 6);
      chk("post_rst_push_idx", 1, ix[1], 1);
      chk("post_rst_push_zero", 0, zf[0], 0);

      // Randomized run against the model from a clean reset.
      @(negedge clk);
      drive(0, 0, 0, 0);
      reset = 1'b0;
      model_reset();
      #1;
      reset = 1'b1;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         model_check();
         mode = int'($urandom_range(0, 3));
         v = ($urandom_range(0, 3) != 0) ? 1 : 0;
         r = ($urandom_range(0, 2) != 0) ? 1 : 0;
         c = ($urandom_range(0, 15) == 0) ? 1 : 0;
         if (mode == 0) oh = 0;
         else if (mode == 1) oh = int'($urandom_range(0, 255));
         else oh = 1 << $urandom_range(0, 7);
         drive(v, oh, r, c);
         @(posedge clk);
         model_step(v, oh, r, c);
      end
      @(negedge clk);
      model_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/oh_to_idx_buffered.md
Name: oh_to_idx_buffered

Overview:
- Registered, flow-controlled one-hot to binary index encoder.
- Adds a valid/ready handshake, a 2-entry output buffer, zero-hot and multi-hot detection, and a saturating error counter.
- Placed between arbiter/tag-match stages and downstream consumers that can stall, e.g. way-select to a fill/writeback path.

Parameters:
- NUM_SIGNALS, 4, width of the one-hot input; must be >= 2.
- DIRECTION, "LSB0", "LSB0": index 0 is bit 0. "MSB0": index 0 is bit NUM_SIGNALS-1.
- INDEX_WIDTH, $clog2(NUM_SIGNALS), width of out_index.
- ERR_COUNT_WIDTH, 8, width of err_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  in_one_hot holds a valid vector.
- in_ready  out  1  block can accept an entry this cycle.
- in_one_hot  in  NUM_SIGNALS  one-hot vector to encode.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_index  out  INDEX_WIDTH  encoded index of the head entry.
- out_zero  out  1  head entry had no bits set.
- out_multi  out  1  head entry had more than one bit set.
- err_count  out  ERR_COUNT_WIDTH  saturating count of accepted zero/multi-hot entries.
- err_count_clear  in  1  synchronous clear of err_count.

Behaviour:
- Encoding (combinational on in_one_hot, captured at push):
  - index = bitwise OR, over every set bit i, of i (LSB0) or NUM_SIGNALS-1-i (MSB0), truncated to INDEX_WIDTH.
  - No priority encoder. A multi-hot input yields the OR of its indices; a zero input yields 0.
  - zero = (in_one_hot == 0).
  - multi = popcount(in_one_hot) > 1.
- Buffer:
  - 2-entry in-order FIFO of {index, zero, multi}, with a 2-bit occupancy count.
  - in_ready = (count < 2), derived from registers only. There is no combinational path from out_ready to in_ready.
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - Simultaneous push and pop: count is unchanged and order is preserved.
  - Full (count 2): in_ready = 0 even if out_ready = 1 in the same cycle.
  - Empty (count 0): out_valid = 0. out_index/out_zero/out_multi are don't-care but must be stable (no X).
- Latency:
  - A push at edge N is visible on out_valid/out_index after edge N, when the buffer was empty.
  - Sustained throughput is 1 entry/cycle while out_ready is held at 1.
- Handshake: once out_valid = 1, the head contents must stay stable until popped.
- Error counter:
  - Increments by 1 on each push where zero | multi.
  - Saturates at 2^ERR_COUNT_WIDTH - 1.
  - err_count_clear has priority: when clear and an error push occur in the same cycle, the result is 0.
- Reset, including assertion mid-operation: all state clears immediately and asynchronously.
  - out_valid = 0, buffer count = 0, err_count = 0, out_index = 0, out_zero = 0, out_multi = 0.
  - in_ready = 0 while reset is asserted; in_ready = 1 on the first cycle after deassertion.
  - In-flight entries are discarded.
- Required assertion: INDEX_WIDTH >= $clog2(NUM_SIGNALS), checked at elaboration.

Test Plan:
- NUM_SIGNALS=8, LSB0, out_ready=1. Push 8'b0001_0000 -> next cycle out_valid=1, out_index=4, out_zero=0, out_multi=0, err_count=0.
- NUM_SIGNALS=8, MSB0. Push 8'b0001_0000 -> out_index=3. Push 8'b1000_0000 -> out_index=0.
- LSB0. Push 8'b0000_0110 -> out_index=3, out_multi=1, err_count=1. Then push 8'h00 -> out_index=0, out_zero=1, err_count=2.
- Backpressure: out_ready=0, offer A=bit1, B=bit5, C=bit7 back to back.
  - in_ready drops to 0 after B is accepted; C is held.
  - Raise out_ready: pops in order 1, 5, then 7 after C is accepted.
  - No loss or duplication.
- ERR_COUNT_WIDTH=2: push 5 zero vectors -> err_count saturates at 3. Then assert err_count_clear in the same cycle as a multi-hot push -> err_count=0.
- With 2 entries buffered, pulse reset low mid-cycle -> out_valid=0 and err_count=0 immediately. After release, in_ready=1 and the next push appears 1 cycle later.
